// File: rtl/param_bank_loader.sv
// Byte-stream loader: bytes land in a shadow bank of little-endian words, and the
// shadow bank is copied to the active bank in one edge once a commit meets swap_en.
module param_bank_loader #(
  parameter int WORD_BYTES = 2,
  parameter int NUM_WORDS  = 27,
  parameter int IDX_W      = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  input  logic [IDX_W-1:0]              byte_idx,
  input  logic                          auto_idx,
  input  logic                          frame_start,
  input  logic                          commit,
  input  logic                          swap_en,
  output logic [NUM_WORDS*8*WORD_BYTES-1:0] words_out,
  output logic                          data_ready,
  output logic                          pending,
  output logic                          err_oob,
  output logic [IDX_W-1:0]              ptr
);

  localparam int W     = 8 * WORD_BYTES;
  localparam int TOTAL = NUM_WORDS * WORD_BYTES;
  localparam logic [IDX_W-1:0] TOTAL_IDX = IDX_W'(TOTAL);

  // Handshake: byte_valid has no ready partner; a byte is consumed on every
  // edge where byte_valid=1, and frame_start/commit/swap_en are single-edge samples.

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } swap_state_t;

  swap_state_t            state;
  logic [NUM_WORDS*W-1:0] shadow;
  logic [IDX_W-1:0]       addr;
  logic                   in_range;

  // A frame_start in auto mode rewinds the pointer for the byte of this very cycle.
  always_comb begin
    addr = byte_idx;
    if (auto_idx) begin
      addr = frame_start ? '0 : ptr;
    end
  end

  assign in_range = (addr < TOTAL_IDX);

  // The state bit is the externally visible pending flag.
  assign pending = (state == PEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      ptr     <= '0;
      err_oob <= 1'b0;
    end else begin
      // Flattened little-endian layout puts byte address a at bits [a*8 +: 8].
      for (int i = 0; i < TOTAL; i++) begin
        if (byte_valid && addr == IDX_W'(i)) begin
          shadow[i*8 +: 8] <= byte_data;
        end
      end

      if (byte_valid && !in_range) begin
        err_oob <= 1'b1;
      end else if (frame_start) begin
        err_oob <= 1'b0;
      end

      if (auto_idx && byte_valid) begin
        ptr <= in_range ? addr + IDX_W'(1) : TOTAL_IDX;
      end else if (frame_start) begin
        ptr <= '0;
      end
    end
  end

  // Swap reads the pre-edge shadow, so a byte written on the swap edge stays shadow-only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      data_ready <= 1'b0;
      words_out  <= '0;
    end else begin
      data_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (commit) begin
            state <= PEND;
          end
        end
        PEND: begin
          if (swap_en) begin
            words_out  <= shadow;
            data_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_bank_loader.sv
// Bench for param_bank_loader: randomized and directed traffic against a byte-array
// reference model, with swapped banks checked through an expected queue.
module tb_param_bank_loader;

  localparam int WB    = 2;
  localparam int NW    = 27;
  localparam int IW    = 6;
  localparam int TOTAL = NW * WB;
  localparam int BW    = TOTAL * 8;

  localparam int WB2    = 4;
  localparam int NW2    = 8;
  localparam int TOTAL2 = NW2 * WB2;
  localparam int BW2    = TOTAL2 * 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic [IW-1:0] byte_idx;
  logic          auto_idx;
  logic          frame_start;
  logic          commit;
  logic          swap_en;
  logic [BW-1:0] words_out;
  logic          data_ready;
  logic          pending;
  logic          err_oob;
  logic [IW-1:0] ptr;

  logic           rst2_n;
  logic           bv2;
  logic [7:0]     bd2;
  logic [IW-1:0]  bi2;
  logic           ai2;
  logic           fs2;
  logic           cm2;
  logic           se2;
  logic [BW2-1:0] words2;
  logic           dr2;
  logic           pend2;
  logic           err2;
  logic [IW-1:0]  ptr2;

  param_bank_loader #(.WORD_BYTES(WB), .NUM_WORDS(NW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_idx(byte_idx), .auto_idx(auto_idx), .frame_start(frame_start),
    .commit(commit), .swap_en(swap_en), .words_out(words_out),
    .data_ready(data_ready), .pending(pending), .err_oob(err_oob), .ptr(ptr)
  );

  param_bank_loader #(.WORD_BYTES(WB2), .NUM_WORDS(NW2), .IDX_W(IW)) dut2 (
    .clk(clk), .rst_n(rst2_n), .byte_valid(bv2), .byte_data(bd2),
    .byte_idx(bi2), .auto_idx(ai2), .frame_start(fs2),
    .commit(cm2), .swap_en(se2), .words_out(words2),
    .data_ready(dr2), .pending(pend2), .err_oob(err2), .ptr(ptr2)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [BW-1:0] exp_q[$];

  logic [7:0] shadow_m[TOTAL];
  logic [7:0] active_m[TOTAL];
  bit         pend_m;
  bit         err_m;
  bit         dr_m;
  int         ptr_m;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack_bank(input bit use_active);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < TOTAL; i++) v[i*8 +: 8] = use_active ? active_m[i] : shadow_m[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TOTAL; i++) begin
      shadow_m[i] = 8'h00;
      active_m[i] = 8'h00;
    end
    pend_m = 0;
    err_m  = 0;
    dr_m   = 0;
    ptr_m  = 0;
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs and advances the model to the state after that edge.
  task automatic drive(input bit bv, input logic [7:0] bd, input int bi, input bit ai,
                       input bit fs, input bit cm, input bit se);
    int a;
    @(negedge clk);
    byte_valid  = bv;
    byte_data   = bd;
    byte_idx    = IW'(bi);
    auto_idx    = ai;
    frame_start = fs;
    commit      = cm;
    swap_en     = se;

    a = ai ? (fs ? 0 : ptr_m) : bi;
    dr_m = 0;
    if (pend_m && se) begin
      for (int i = 0; i < TOTAL; i++) active_m[i] = shadow_m[i];
      exp_q.push_back(pack_bank(1'b0));
      pend_m = 0;
      dr_m   = 1;
    end else if (!pend_m && cm) begin
      pend_m = 1;
    end
    if (fs) err_m = 0;
    if (bv) begin
      if (a < TOTAL) shadow_m[a] = bd;
      else err_m = 1;
    end
    if (ai && bv) ptr_m = (a + 1 < TOTAL) ? a + 1 : TOTAL;
    else if (fs) ptr_m = 0;
  endtask

  task automatic idle(input int n, input bit ai);
    for (int k = 0; k < n; k++) drive(0, 8'h00, 0, ai, 0, 0, 0);
  endtask

  task automatic reset_main();
    @(negedge clk);
    rst_n = 0;
    byte_valid = 0; frame_start = 0; commit = 0; swap_en = 0;
    model_reset();
    exp_q.delete();
    #1;
    check("async_reset_words", words_out, '0);
    check("async_reset_pending", BW'(pending), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    check("pending", BW'(pending), BW'(pend_m));
    check("err_oob", BW'(err_oob), BW'(err_m));
    check("ptr", BW'(ptr), BW'(ptr_m));
    check("data_ready", BW'(data_ready), BW'(dr_m));
    check("words_out_stable", words_out, pack_bank(1'b1));
    if (data_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got data_ready=1 expected no pending swap at %0t", $time);
      end else begin
        check("sb_bank", words_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [BW2-1:0] exp2;
  bit got;

  initial begin
    model_reset();
    rst_n = 0; byte_valid = 0; byte_data = 0; byte_idx = 0; auto_idx = 0;
    frame_start = 0; commit = 0; swap_en = 0;
    rst2_n = 0; bv2 = 0; bd2 = 0; bi2 = 0; ai2 = 0; fs2 = 0; cm2 = 0; se2 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Full auto-mode packet with swap_en held high.
    drive(0, 8'h00, 0, 1, 1, 0, 1);
    for (int i = 0; i < TOTAL; i++) drive(1, 8'(i + 1), 0, 1, 0, 0, 1);
    drive(0, 8'h00, 0, 1, 0, 1, 1);
    drive(0, 8'h00, 0, 1, 0, 0, 1);
    idle(1, 1);
    check("t1_word0", BW'(words_out[0 +: 16]), BW'(16'h0201));
    check("t1_word26", BW'(words_out[26*16 +: 16]), BW'(16'h3635));
    check("t1_ptr", BW'(ptr), BW'(54));
    check("t1_err", BW'(err_oob), '0);

    // Explicit mode, swap held off for 100 cycles.
    drive(1, 8'hAA, 53, 0, 0, 0, 0);
    drive(1, 8'h55, 52, 0, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0, 1, 0);
    idle(100, 0);
    drive(0, 8'h00, 0, 0, 0, 0, 1);
    idle(1, 0);
    check("t2_word26", BW'(words_out[26*16 +: 16]), BW'(16'hAA55));

    // Overflow: 55 bytes into a 54-byte bank.
    drive(0, 8'h00, 0, 1, 1, 0, 0);
    for (int i = 0; i <= TOTAL; i++) drive(1, 8'($urandom_range(0, 255)), 0, 1, 0, 0, 0);
    idle(1, 1);
    check("t3_err_set", BW'(err_oob), BW'(1));
    check("t3_ptr_sat", BW'(ptr), BW'(54));
    drive(0, 8'h00, 0, 1, 1, 0, 0);
    idle(1, 1);
    check("t3_err_clr", BW'(err_oob), '0);
    check("t3_ptr_clr", BW'(ptr), '0);
    drive(0, 8'h00, 0, 1, 0, 1, 0);
    drive(0, 8'h00, 0, 1, 0, 0, 1);
    idle(1, 1);

    // Byte written on the swap edge stays in shadow.
    drive(1, 8'h11, 0, 0, 0, 0, 0);
    drive(1, 8'h11, 1, 0, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0, 1, 0);
    drive(1, 8'h22, 0, 0, 0, 0, 1);
    idle(1, 0);
    check("t4_word0_old", BW'(words_out[0 +: 16]), BW'(16'h1111));
    drive(0, 8'h00, 0, 0, 0, 1, 0);
    drive(0, 8'h00, 0, 0, 0, 0, 1);
    idle(1, 0);
    check("t4_word0_new", BW'(words_out[0 +: 16]), BW'(16'h1122));

    // Commit+swap_en in IDLE, then repeated commits in PEND.
    drive(0, 8'h00, 0, 0, 0, 1, 1);
    idle(1, 0);
    check("t5_pending_after_idle_pair", BW'(pending), BW'(1));
    drive(0, 8'h00, 0, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 0, 0, 1, 0);
    drive(0, 8'h00, 0, 0, 0, 1, 0);
    drive(0, 8'h00, 0, 0, 0, 1, 1);
    idle(2, 0);
    check("t5_pending_consumed", BW'(pending), '0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom_range(0, 255)), $urandom_range(0, 63),
            $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3);
    end
    idle(2, 0);

    // Reset in the middle of PEND.
    drive(1, 8'h5A, 3, 0, 0, 1, 0);
    reset_main();
    idle(3, 0);

    // Wider words on the second instance.
    @(negedge clk);
    rst2_n = 1; ai2 = 1; fs2 = 1;
    @(negedge clk);
    fs2 = 0;
    for (int i = 0; i < TOTAL2; i++) begin
      bv2 = 1;
      bd2 = 8'(8'h10 + i);
      @(negedge clk);
    end
    bv2 = 0; cm2 = 1; se2 = 1;
    @(negedge clk);
    cm2 = 0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #1;
      if (dr2) got = 1;
    end
    check("sweep_dr_seen", BW'(got), BW'(1));
    for (int i = 0; i < TOTAL2; i++) exp2[i*8 +: 8] = 8'(8'h10 + i);
    check("sweep_word7", BW'(words2[7*32 +: 32]), BW'(32'h2F2E2D2C));
    check("sweep_bank", BW'(words2), BW'(exp2));

    @(negedge clk);
    se2 = 0; fs2 = 1; bv2 = 1; bd2 = 8'hA0;
    @(negedge clk);
    fs2 = 0; bd2 = 8'hA1; cm2 = 1;
    @(negedge clk);
    cm2 = 0; bd2 = 8'hA2;
    @(posedge clk);
    #1;
    check("sweep_pend_before_rst", BW'(pend2), BW'(1));
    check("sweep_ptr_before_rst", BW'(ptr2), BW'(3));
    #1;
    rst2_n = 0;
    #1;
    check("sweep_rst_words", BW'(words2), '0);
    check("sweep_rst_pend", BW'(pend2), '0);
    check("sweep_rst_ptr", BW'(ptr2), '0);
    check("sweep_rst_err", BW'(err2), '0);
    check("sweep_rst_dr", BW'(dr2), '0);
    se2 = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("sweep_rst_no_dr", BW'(dr2), '0);
    end
    bv2 = 0; se2 = 0;

    idle(3, 0);
    check("sb_queue_drained", BW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
